// File: rtl/sample_serializer.sv
// sample_serializer: captures decimated samples on a one-cycle strobe, buffers
// them in a small FIFO and shifts each word out MSB-first on sdo/sclk/frame.
// Every output is a flop. The registered outputs are built from the next-state
// values, so frame and the MSB appear in the cycle right after the pop edge.
// Optional feature: define SAMPLE_SERIALIZER_PARITY_EN to append an even-parity
// bit after the LSB of every word.
module sample_serializer #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            new_data,
    input  logic                            tx_en,
    input  logic                            ovf_clr,
    output logic                            sdo,
    output logic                            sclk,
    output logic                            frame,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_e;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [NBITS-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   sdo_q, sdo_d, sclk_q, sclk_d;
    logic                   frame_q, frame_d, busy_q, busy_d;
    logic                   pop_s, push_s;
    logic [NBITS-1:0]       load_s;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
    assign load_s = {mem_q[rd_q], even_parity(mem_q[rd_q])};
`else
    assign load_s = mem_q[rd_q];
`endif

    // FIFO bookkeeping: a push is taken when there is room or the head leaves on the same edge.
    always_comb begin
        push_s = new_data && ((count_q < CNT_W'(FIFO_DEPTH)) || pop_s);
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        if (push_s) begin
            wr_d = wr_q + PTR_W'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + PTR_W'(1);
        end else begin
            rd_d = rd_q;
        end
        if (new_data && !push_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sample storage; a write into a full FIFO lands in the slot being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_q] <= data_in;
        end
    end

    // Next-state logic: pop in IDLE, bit/divider sequencing in SHIFT, fixed gap after each word.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_en && (count_q != {CNT_W{1'b0}})) begin
                    pop_s   = 1'b1;
                    shift_d = load_s;
                    div_d   = {DIV_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = {DIV_W{1'b0}};
                    shift_d = {shift_q[NBITS-2:0], 1'b0};
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        bit_d   = {BIT_W{1'b0}};
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = {DIV_W{1'b0}};
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = {DIV_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Output decode from next state so the flopped outputs line up with the state they describe.
    always_comb begin
        if (state_d == SHIFT) begin
            frame_d = 1'b1;
            sdo_d   = shift_d[NBITS-1];
            sclk_d  = (div_d >= DIV_W'(CLK_DIV / 2));
        end else begin
            frame_d = 1'b0;
            sdo_d   = 1'b0;
            sclk_d  = 1'b0;
        end
        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State, FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            shift_q <= {NBITS{1'b0}};
            wr_q    <= {PTR_W{1'b0}};
            rd_q    <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    assign sdo        = sdo_q;
    assign sclk       = sclk_q;
    assign frame      = frame_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer (DATA_W=12, FIFO_DEPTH=4, CLK_DIV=4).
module tb_sample_serializer;
    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV    = 4;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              new_data, tx_en, ovf_clr;
    logic              sdo, sclk, frame, busy, overflow;
    logic [2:0]        fifo_count;

    int checks = 0;
    int errors = 0;

    sample_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .new_data(new_data),
        .tx_en(tx_en), .ovf_clr(ovf_clr), .sdo(sdo), .sclk(sclk), .frame(frame),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        data_in  = d;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
    endtask

    // Reset asserted between edges; released between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step();
    endtask

    // Expected serial word as it appears on the wire (MSB first, optional parity last).
    function automatic logic [15:0] exp_word(input logic [DATA_W-1:0] d);
`ifdef SAMPLE_SERIALIZER_PARITY_EN
        return {3'b000, d, ^d};
`else
        return {4'b0000, d};
`endif
    endfunction

    // Wait (bounded) for frame, then sample sdo while sclk is high in each bit.
    task automatic receive_word(output logic [15:0] w);
        int waited;
        int low;
        waited = 0;
        low = 0;
        w = 16'h0000;
        while (frame !== 1'b1 && waited < 300) begin
            step();
            waited++;
        end
        check("frame_start", {31'd0, frame}, 32'd1);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                if (frame !== 1'b1) low++;
                if (c == 2) w = {w[14:0], sdo};
                step();
            end
        end
        check("frame_hold", low, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] ew;
        int hits;

        data_in = 12'h000; new_data = 1'b0; tx_en = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_outputs", {27'd0, sdo, sclk, frame, busy, overflow}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        #4 rst_n = 1'b1;
        step();

        // Single word 12'hA5C, checked cycle by cycle.
        tx_en = 1'b1;
        push(12'hA5C);
        check("w1_not_yet", {31'd0, frame}, 32'd0);
        check("w1_count_t0", {29'd0, fifo_count}, 32'd1);
        step();
        check("w1_count_t1", {29'd0, fifo_count}, 32'd0);
        ew = exp_word(12'hA5C);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                check("w1_bit", {29'd0, frame, sclk, sdo},
                      {29'd0, 1'b1, (c >= 2) ? 1'b1 : 1'b0, ew[NB-1-b]});
                step();
            end
        end
        for (int g = 0; g < CLK_DIV; g++) begin
            check("w1_gap", {28'd0, frame, sclk, sdo, busy}, 32'd1);
            step();
        end
        check("w1_idle_busy", {31'd0, busy}, 32'd0);

        // Overflow: five writes into a four-deep FIFO with transmit held off.
        do_reset();
        tx_en = 1'b0;
        for (int i = 1; i <= 5; i++) push(DATA_W'(i));
        check("ovf_count", {29'd0, fifo_count}, 32'd4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_no_tx", {31'd0, frame}, 32'd0);
        tx_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            receive_word(w);
            check("ovf_word", {16'd0, w}, {16'd0, exp_word(DATA_W'(i))});
        end
        for (int g = 0; g < CLK_DIV + 2; g++) step();
        check("ovf_drained", {29'd0, fifo_count}, 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // tx_en dropped during bit 6 of the first of two queued words.
        do_reset();
        tx_en = 1'b0;
        push(12'h123);
        push(12'h456);
        tx_en = 1'b1;
        step();
        check("txen_count", {29'd0, fifo_count}, 32'd1);
        w = 16'h0000;
        for (int k = 0; k < NB * CLK_DIV; k++) begin
            if (k % CLK_DIV == 2) w = {w[14:0], sdo};
            if (k == 26) tx_en = 1'b0;
            step();
        end
        check("txen_word", {16'd0, w}, {16'd0, exp_word(12'h123)});
        hits = 0;
        for (int k = 0; k < 60; k++) begin
            if (frame === 1'b1) hits++;
            step();
        end
        check("txen_no_second", hits, 0);
        check("txen_count_kept", {29'd0, fifo_count}, 32'd1);
        check("txen_idle", {31'd0, busy}, 32'd0);

        // Push and pop on the same edge while full.
        do_reset();
        tx_en = 1'b0;
        push(12'h00A); push(12'h00B); push(12'h00C); push(12'h00D);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        tx_en = 1'b1;
        push(12'h00E);
        check("pp_count", {29'd0, fifo_count}, 32'd4);
        check("pp_no_ovf", {31'd0, overflow}, 32'd0);
        check("pp_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            receive_word(w);
            check("pp_word", {16'd0, w}, {16'd0, exp_word(DATA_W'(12'h00A + i))});
        end

`ifdef SAMPLE_SERIALIZER_PARITY_EN
        // Parity bit: 12'h001 -> 1, 12'h003 -> 0.
        do_reset();
        tx_en = 1'b1;
        push(12'h001);
        push(12'h003);
        receive_word(w);
        check("par_001", {16'd0, w}, 32'h0003);
        receive_word(w);
        check("par_003", {16'd0, w}, 32'h0006);
`endif

        // Reset in the middle of a word with overflow set.
        do_reset();
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) push(12'hFFF);
        tx_en = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("mid_pre_frame", {30'd0, frame, overflow}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {27'd0, sdo, sclk, frame, busy, overflow}, 32'd0);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        #3 rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (frame === 1'b1 || busy === 1'b1 || sdo === 1'b1) hits++;
        end
        check("mid_no_residual", hits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
